// File: rtl/weight_fetch_pkg.sv
// ----------------------------------------------------------------------------
// weight_fetch_pkg
// Shared types and constants for the weight fetch unit.
//   - wfu_state_t  : fetch FSM state encoding
//   - ADDR_LIMIT   : number of words in the weight store (25 banks x 2048 rows)
//   - BANK_COUNT / ROW_BITS / BANK_BITS : weight-store geometry
//   - ADDR_W / COUNT_W / STRIDE_W / DATA_W / SRAM_ADDR_W : datapath widths
//   - wrap_addr()  : address increment with wrap at the store limit
// Optional feature macro used by the unit: WFU_STRIDE_EN.
// ----------------------------------------------------------------------------
package weight_fetch_pkg;

  localparam int ADDR_LIMIT  = 51200;
  localparam int BANK_COUNT  = 25;
  localparam int ROW_BITS    = 11;
  localparam int BANK_BITS   = 5;
  localparam int ADDR_W      = 16;
  localparam int COUNT_W     = 16;
  localparam int STRIDE_W    = 11;
  localparam int DATA_W      = 32;
  localparam int SRAM_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } wfu_state_t;

  // Bank/row fields are contiguous, so a row overflow carries into the bank
  // field by plain addition. The increment is at most one stride (< limit),
  // so a single subtraction is enough to fold the sum back into range.
  function automatic logic [ADDR_W-1:0] wrap_addr(
    input logic [ADDR_W-1:0] cur,
    input logic [ADDR_W-1:0] incr,
    input logic [ADDR_W:0]   limit
  );
    logic [ADDR_W:0] sum;
    sum = {1'b0, cur} + {1'b0, incr};
    if (sum >= limit) begin
      sum = sum - limit;
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/weight_fetch_fifo.sv
// ----------------------------------------------------------------------------
// weight_fetch_fifo
// First-word-fall-through FIFO: the head entry is visible on o_data whenever
// o_empty is low. Simultaneous push and pop leave the occupancy unchanged.
// The caller guarantees no push when full and no pop when empty.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   i_push, i_data   : write strobe and data
//   i_pop            : consume the head entry
//   o_data           : head entry
//   o_full, o_empty  : occupancy flags
//   o_count          : current occupancy (0..DEPTH)
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// ----------------------------------------------------------------------------
module weight_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/weight_fetch_unit.sv
// ----------------------------------------------------------------------------
// weight_fetch_unit
// Fetches a block of weight words from the weight SRAM controller and streams
// them to the PE array through a small FWFT FIFO. One read is outstanding at
// most; peak rate is one word every two cycles.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; only state in which start is accepted
// ISSUE  | read request on the bus (r_sram_r_en=1) or stalled on a full FIFO
// WAIT   | one read outstanding, waiting for i_sram_d_ready
// DRAIN  | all reads returned, waiting for the w_last handshake
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   i_start                 : one-cycle fetch request
//   i_base_addr[15:0]       : first word address ([15:11] bank, [10:0] row)
//   i_word_count[15:0]      : number of words to fetch
//   i_stride[10:0]          : per-word address increment (WFU_STRIDE_EN only)
//   o_busy, o_done          : transfer in progress / one-cycle completion
//   o_sram_addr[31:0]       : SRAM read address ([31:16] always 0)
//   o_sram_r_en, o_sram_w_en: SRAM read request / write request (tied 0)
//   i_sram_r_d[31:0]        : SRAM read data, valid with i_sram_d_ready
//   i_sram_d_ready          : read-data strobe, one cycle after o_sram_r_en
//   o_w_valid/o_w_data/o_w_last, i_w_ready : weight stream to the PE array
//
// Build option: define WFU_STRIDE_EN to add i_stride; otherwise the address
// increment is fixed at 1.
// ----------------------------------------------------------------------------
module weight_fetch_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_LIMIT = weight_fetch_pkg::ADDR_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [15:0] i_base_addr,
  input  logic [15:0] i_word_count,
`ifdef WFU_STRIDE_EN
  input  logic [10:0] i_stride,
`endif
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_sram_addr,
  output logic        o_sram_r_en,
  output logic        o_sram_w_en,
  input  logic [31:0] i_sram_r_d,
  input  logic        i_sram_d_ready,
  output logic        o_w_valid,
  output logic [31:0] o_w_data,
  output logic        o_w_last,
  input  logic        i_w_ready
);

  import weight_fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] LIMIT_V = (ADDR_W+1)'(ADDR_LIMIT);

  wfu_state_t         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_issued;
  logic               r_busy;
  logic               r_done;
  logic               r_sram_r_en;
`ifdef WFU_STRIDE_EN
  logic [STRIDE_W-1:0] r_stride;
`endif

  logic [ADDR_W-1:0]  w_incr;
  logic [ADDR_W-1:0]  w_addr_next;
  logic               w_push;
  logic               w_pop;
  logic               w_push_last;
  logic [DATA_W:0]    w_fifo_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [CNT_W-1:0]   w_fifo_count_next;
  logic               w_room_next;

`ifdef WFU_STRIDE_EN
  assign w_incr = {{(ADDR_W-STRIDE_W){1'b0}}, r_stride};
`else
  assign w_incr = ADDR_W'(1);
`endif

  assign w_addr_next = wrap_addr(r_addr, w_incr, LIMIT_V);

  // Data strobes outside WAIT are stray and dropped.
  assign w_push      = (r_state == ST_WAIT) && i_sram_d_ready;
  assign w_pop       = o_w_valid && i_w_ready;
  // r_issued already counts the word being returned.
  assign w_push_last = (r_issued == r_count);

  // Occupancy after this edge decides whether the next read can go out
  // straight from WAIT, which is what gives back-to-back 2-cycle issue.
  assign w_fifo_count_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_room_next       = (w_fifo_count_next < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sram_r_en <= 1'b0;
`ifdef WFU_STRIDE_EN
      r_stride    <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (i_start && !r_done) begin
            if (i_word_count != '0) begin
              r_addr      <= i_base_addr;
              r_count     <= i_word_count;
              r_issued    <= '0;
`ifdef WFU_STRIDE_EN
              r_stride    <= i_stride;
`endif
              r_busy      <= 1'b1;
              // FIFO is always empty in IDLE, so the first read goes out now.
              r_sram_r_en <= 1'b1;
              r_state     <= ST_ISSUE;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (r_sram_r_en) begin
            r_sram_r_en <= 1'b0;
            r_addr      <= w_addr_next;
            r_issued    <= r_issued + COUNT_W'(1);
            r_state     <= ST_WAIT;
          end else if (!w_fifo_full) begin
            r_sram_r_en <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_sram_d_ready) begin
            if (r_issued < r_count) begin
              r_sram_r_en <= w_room_next;
              r_state     <= ST_ISSUE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_fifo_head[DATA_W]) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Each entry carries its own last flag alongside the data word.
  weight_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  ({w_push_last, i_sram_r_d}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_sram_addr = {16'h0000, r_addr};
  assign o_sram_r_en = r_sram_r_en;
  assign o_sram_w_en = 1'b0;
  assign o_w_valid   = !w_fifo_empty;
  assign o_w_data    = w_fifo_head[DATA_W-1:0];
  assign o_w_last    = w_fifo_head[DATA_W] && !w_fifo_empty;

endmodule

// File: tb/tb_weight_fetch_unit.sv
module tb_weight_fetch_unit;
  import weight_fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] base = '0;
  logic [15:0] wcount = '0;
`ifdef WFU_STRIDE_EN
  logic [10:0] stride = '0;
`endif
  logic        o_busy, o_done, o_sram_r_en, o_sram_w_en;
  logic [31:0] o_sram_addr, o_w_data;
  logic        o_w_valid, o_w_last;
  logic [31:0] sram_r_d = '0;
  logic        sram_d_ready = 1'b0;
  logic        w_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fifo_ovf = 0;
  logic [31:0] addr_log[$];
  int          ren_cyc[$];
  logic [31:0] rx_data[$];
  logic        rx_last[$];

  weight_fetch_unit #(.FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .i_start        (i_start),
    .i_base_addr    (base),
    .i_word_count   (wcount),
`ifdef WFU_STRIDE_EN
    .i_stride       (stride),
`endif
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_sram_addr    (o_sram_addr),
    .o_sram_r_en    (o_sram_r_en),
    .o_sram_w_en    (o_sram_w_en),
    .i_sram_r_d     (sram_r_d),
    .i_sram_d_ready (sram_d_ready),
    .o_w_valid      (o_w_valid),
    .o_w_data       (o_w_data),
    .o_w_last       (o_w_last),
    .i_w_ready      (w_ready)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // SRAM model: answers one cycle after a read request with addr ^ 0xA5A5.
  always begin
    logic        ren_q;
    logic        rst_q;
    logic [31:0] addr_q;
    @(posedge clock);
    ren_q  = o_sram_r_en;
    rst_q  = reset;
    addr_q = o_sram_addr;
    #1;
    sram_d_ready = ren_q && !rst_q;
    sram_r_d     = addr_q ^ 32'h0000A5A5;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (o_sram_r_en) begin
        addr_log.push_back(o_sram_addr);
        ren_cyc.push_back(cyc);
      end
      if (o_w_valid && w_ready) begin
        rx_data.push_back(o_w_data);
        rx_last.push_back(o_w_last);
      end
      if (o_done) done_cnt++;
      if (dut.w_push && dut.w_fifo_full) fifo_ovf++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    ren_cyc.delete();
    rx_data.delete();
    rx_last.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] c, input logic [10:0] s);
    base = b;
    wcount = c;
`ifdef WFU_STRIDE_EN
    stride = s;
`endif
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 32'(o_done), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(o_busy), 32'd0);
    chk({tag, "_done"},  32'(o_done), 32'd0);
    chk({tag, "_ren"},   32'(o_sram_r_en), 32'd0);
    chk({tag, "_wen"},   32'(o_sram_w_en), 32'd0);
    chk({tag, "_addr"},  o_sram_addr, 32'h0);
    chk({tag, "_valid"}, 32'(o_w_valid), 32'd0);
    chk({tag, "_last"},  32'(o_w_last), 32'd0);
  endtask

  initial begin
    int n;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // base 0, 4 words, plus a start while busy that must be ignored
    clear_logs();
    w_ready = 1'b1;
    pulse_start(16'h0000, 16'd4, 11'd1);
    chk("t1_busy", 32'(o_busy), 32'd1);
    tick();
    pulse_start(16'h3000, 16'd7, 11'd1);
    wait_done("t1", 40);
    chk("t1_busy_at_done", 32'(o_busy), 32'd0);
    tick();
    chk("t1_nreads", 32'(addr_log.size()), 32'd4);
    chk("t1_nwords", 32'(rx_data.size()), 32'd4);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), addr_log[i], 32'(i));
      chk($sformatf("t1_data%0d", i), rx_data[i], 32'(i) ^ 32'h0000A5A5);
      chk($sformatf("t1_last%0d", i), 32'(rx_last[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_gap%0d", i), 32'(ren_cyc[i+1] - ren_cyc[i]), 32'd2);
    end

    // row overflow into bank; start coinciding with done is ignored
    clear_logs();
    pulse_start(16'h07FE, 16'd3, 11'd1);
    wait_done("t2", 40);
    base = 16'h4000;
    wcount = 16'd2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t2_start_at_done_busy", 32'(o_busy), 32'd0);
    repeat (5) tick();
    chk("t2_nreads", 32'(addr_log.size()), 32'd3);
    chk("t2_addr0", addr_log[0], 32'h07FE);
    chk("t2_addr1", addr_log[1], 32'h07FF);
    chk("t2_addr2", addr_log[2], 32'h0800);
    chk("t2_data2", rx_data[2], 32'h0000A5A5 ^ 32'h0800);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // wrap at the end of the store
    clear_logs();
    pulse_start(16'hC7FF, 16'd2, 11'd1);
    wait_done("t3", 40);
    tick();
    chk("t3_nreads", 32'(addr_log.size()), 32'd2);
    chk("t3_addr0", addr_log[0], 32'hC7FF);
    chk("t3_addr1", addr_log[1], 32'h0000);
    chk("t3_data0", rx_data[0], 32'h0000625A);
    chk("t3_data1", rx_data[1], 32'h0000A5A5);
    chk("t3_last1", 32'(rx_last[1]), 32'd1);

    // backpressure: FIFO fills, reads stop, then all 10 words stream out
    clear_logs();
    w_ready = 1'b0;
    pulse_start(16'h0010, 16'd10, 11'd1);
    repeat (40) tick();
    chk("t4_reads_while_stalled", 32'(addr_log.size()), 32'd4);
    chk("t4_ren_held_low", 32'(o_sram_r_en), 32'd0);
    chk("t4_valid_while_stalled", 32'(o_w_valid), 32'd1);
    chk("t4_nothing_taken", 32'(rx_data.size()), 32'd0);
    chk("t4_addr3", addr_log[3], 32'h0013);
    w_ready = 1'b1;
    wait_done("t4", 80);
    tick();
    chk("t4_nreads", 32'(addr_log.size()), 32'd10);
    chk("t4_nwords", 32'(rx_data.size()), 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_data%0d", i), rx_data[i], (32'h10 + 32'(i)) ^ 32'h0000A5A5);
      chk($sformatf("t4_last%0d", i), 32'(rx_last[i]), (i == 9) ? 32'd1 : 32'd0);
    end

    // reset in WAIT after 2 of 6 words
    clear_logs();
    pulse_start(16'h0200, 16'd6, 11'd1);
    n = 0;
    while (rx_data.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    chk("t5_two_words_seen", 32'(rx_data.size()), 32'd2);
    n = 0;
    while (dut.r_state != ST_WAIT && n < 10) begin
      tick();
      n++;
    end
    chk("t5_in_wait", 32'(dut.r_state == ST_WAIT), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_outputs("t5_rst");
    reset = 1'b0;
    repeat (10) tick();
    chk("t5_no_done_after_abort", 32'(done_cnt), 32'd0);
    chk("t5_idle_busy", 32'(o_busy), 32'd0);
    clear_logs();
    pulse_start(16'h0300, 16'd1, 11'd1);
    wait_done("t5b", 20);
    tick();
    chk("t5b_nwords", 32'(rx_data.size()), 32'd1);
    chk("t5b_data", rx_data[0], 32'h0000A6A5);
    chk("t5b_last", 32'(rx_last[0]), 32'd1);
    chk("t5b_done_cnt", 32'(done_cnt), 32'd1);

    // zero-length request
    clear_logs();
    pulse_start(16'h0500, 16'd0, 11'd1);
    chk("t6_done_next", 32'(o_done), 32'd1);
    chk("t6_busy", 32'(o_busy), 32'd0);
    tick();
    chk("t6_done_one_cycle", 32'(o_done), 32'd0);
    repeat (3) tick();
    chk("t6_no_reads", 32'(addr_log.size()), 32'd0);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);

`ifdef WFU_STRIDE_EN
    clear_logs();
    pulse_start(16'h0100, 16'd3, 11'd16);
    wait_done("t7", 40);
    tick();
    chk("t7_nreads", 32'(addr_log.size()), 32'd3);
    chk("t7_addr0", addr_log[0], 32'h0100);
    chk("t7_addr1", addr_log[1], 32'h0110);
    chk("t7_addr2", addr_log[2], 32'h0120);
`endif

    chk("fifo_push_when_full", 32'(fifo_ovf), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weight_fetch_unit.md
WEIGHT_FETCH_UNIT -- requirements
Module: weight_fetch_unit

Interface
REQ-001 Parameter FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
REQ-002 Parameter ADDR_LIMIT, 51200, words in the weight store (25 banks x 2048 rows).
REQ-003 clock  in  1  clock; all logic on the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to fetch a weight block.
REQ-006 base_addr  in  16  first word address; bits [15:11] = bank, bits [10:0] = row.
REQ-007 word_count  in  16  number of words to fetch.
REQ-008 stride  in  11  address increment per word; present only with WFU_STRIDE_EN.
REQ-009 busy  out  1  high from accepted start until done.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 sram_addr  out  32  read address to the weight SRAM controller; bits [31:16] = 0.
REQ-012 sram_r_en  out  1  read request to the SRAM controller.
REQ-013 sram_w_en  out  1  write request; tied 0.
REQ-014 sram_r_d  in  32  read data; valid while sram_d_ready = 1.
REQ-015 sram_d_ready  in  1  read-data strobe, one cycle after the accepted sram_r_en.
REQ-016 w_valid / w_data[31:0] / w_last  out  weight stream to the PE array.
REQ-017 w_ready  in  1  PE array accepts a word when w_valid & w_ready.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, DRAIN; all outputs registered.
REQ-019 IDLE: start with word_count > 0 latches base_addr, word_count and stride, sets busy, and moves to ISSUE.
REQ-020 IDLE: start with word_count = 0 pulses done on the next cycle, with no SRAM access and busy staying 0.
REQ-021 start while busy is ignored.
REQ-022 ISSUE: when FIFO occupancy < FIFO_DEPTH, assert sram_r_en for exactly one cycle with the current sram_addr, then go to WAIT; otherwise hold sram_r_en low and stay in ISSUE.
REQ-023 At most one read is outstanding at any time.
REQ-024 WAIT: on sram_d_ready, push sram_r_d into the FIFO; if issued words < word_count go to ISSUE, else go to DRAIN.
REQ-025 Peak throughput is 1 word per 2 cycles.
REQ-026 Address update after each issue: next = current + increment; if next >= ADDR_LIMIT, subtract ADDR_LIMIT (wrap from 0xC7FF to 0x0000).
REQ-027 Row overflow carries into the bank field naturally (0x07FF + 1 = 0x0800).
REQ-028 FIFO: first-word fall-through; w_valid = not empty.
REQ-029 FIFO: a simultaneous push and pop in one cycle keeps occupancy unchanged.
REQ-030 FIFO: a push when full cannot occur by construction; the bench asserts this.
REQ-031 w_last is high with the word whose index is word_count-1.
REQ-032 DRAIN: wait for the handshake on the w_last word, then pulse done, clear busy, and go to IDLE.
REQ-033 A start in the same cycle as done is ignored; a start is accepted only from IDLE.
REQ-034 sram_d_ready received outside WAIT is ignored.

Reset
REQ-035 Reset outputs: state=IDLE, busy=0, done=0, sram_r_en=0, sram_addr=0, FIFO empty, w_valid=0, w_last=0.
REQ-036 Reset mid-operation aborts the transfer and flushes the FIFO; no done pulse follows.

Configuration
REQ-037 WFU_STRIDE_EN defined: the stride port exists, increment = stride, and stride = 0 re-reads the same word word_count times.
REQ-038 WFU_STRIDE_EN undefined: the stride port is absent and increment is fixed at 1.

Structure
REQ-039 Package weight_fetch_pkg holds: FSM state enum, ADDR_LIMIT, BANK_COUNT=25, ROW_BITS=11, address and count widths.
REQ-040 Sub-module weight_fetch_fifo is a parameterised FWFT FIFO (push, pop, full, empty, count).

Verification
REQ-041 base=0x0000, count=4, w_ready=1, SRAM model returns addr^0xA5A5 -> words 0..3 in order, w_last on 4th, done once, sram_r_en pulses 2 cycles apart.
REQ-042 base=0x07FE, count=3 -> sram_addr sequence 0x07FE, 0x07FF, 0x0800.
REQ-043 base=0xC7FF, count=2 -> sram_addr sequence 0xC7FF, 0x0000.
REQ-044 count=10, w_ready=0 for 40 cycles -> exactly FIFO_DEPTH reads issued and sram_r_en then held low; after w_ready=1 all 10 words arrive in order.
REQ-045 Reset asserted in WAIT after 2 of 6 words -> all outputs at reset values next cycle; a new start with count=1 completes normally.
REQ-046 count=0 -> done pulses 1 cycle after start; sram_r_en never asserted. With WFU_STRIDE_EN, stride=16, base=0x0100, count=3 -> addresses 0x0100, 0x0110, 0x0120.
